// File: rtl/mem_io_pkg.sv
// Shared types and helpers for the memory/IO load-store bridge.
package mem_io_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM,
        ST_MEM_WAIT,
        ST_IO,
        ST_RESP
    } state_t;

    localparam logic [1:0] SZ_B   = 2'd0;
    localparam logic [1:0] SZ_H   = 2'd1;
    localparam logic [1:0] SZ_W   = 2'd2;
    localparam logic [1:0] SZ_ILL = 2'd3;

    localparam logic [31:0] IO_BASE_DFLT = 32'hFFFF_FC00;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wdata;
    } mem_req_t;

    // Byte-enable pattern for an access of the given size at byte offset off.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    lane_mask = 4'b0001 << off;
            SZ_H:    lane_mask = 4'b0011 << off;
            SZ_W:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mem_io_bridge_lane_align.sv
// mem_lane_align: store lane replication/mask and load shift/extend (combinational).
module mem_lane_align
    import mem_io_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        sgn,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  we_mask_c,
    output logic [31:0] wdata_rep_c,
    output logic [31:0] rdata_ext_c
);

    logic [31:0] shifted;

    always_comb begin
        we_mask_c = lane_mask(size, off);
        shifted   = rdata >> {off, 3'b000};
        case (size)
            SZ_B: begin
                wdata_rep_c = {4{wdata[7:0]}};
                rdata_ext_c = {{24{sgn & shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                wdata_rep_c = {2{wdata[15:0]}};
                rdata_ext_c = {{16{sgn & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                wdata_rep_c = wdata;
                rdata_ext_c = shifted;
            end
        endcase
    end

endmodule

// File: rtl/mem_io_bridge.sv
// Registered load/store bridge to data RAM or memory-mapped IO channels.
// Optional IO watchdog enabled by defining MEM_IO_TIMEOUT_EN.
module mem_io_bridge
    import mem_io_pkg::*;
#(
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       IO_CH          = 4,
    parameter int unsigned       IO_W           = 16,
    parameter logic [ADDR_W-1:0] IO_BASE        = ADDR_W'(IO_BASE_DFLT),
    parameter int unsigned       IO_STRIDE_LOG2 = 4,
    parameter int unsigned       MEM_LAT        = 1,
    parameter int unsigned       TIMEOUT_CYC    = 255
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [1:0]             req_size,
    input  logic                   req_signed,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [31:0]            req_wdata,
    output logic                   rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic                   mem_en,
    output logic [3:0]             mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [31:0]            mem_wdata,
    input  logic [31:0]            mem_rdata,
    output logic [IO_CH-1:0]       io_cs,
    output logic                   io_we,
    output logic [IO_W-1:0]        io_wdata,
    input  logic [IO_CH*IO_W-1:0]  io_rdata,
    input  logic [IO_CH-1:0]       io_ready
);

    localparam int unsigned CH_W  = (IO_CH > 1) ? $clog2(IO_CH) : 1;
    localparam int unsigned LAT_W = 3;

    state_t            state_q, state_d;
    mem_req_t          req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [LAT_W-1:0]  lat_q, lat_d;

    logic [ADDR_W-1:0] io_off, io_idx;
    logic              in_io, io_bad, misalign;

    logic              req_ready_d, rsp_valid_d, rsp_err_d, mem_en_d, io_we_d;
    logic [31:0]       rsp_rdata_d, mem_wdata_d;
    logic [3:0]        mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [IO_CH-1:0]  io_cs_d;
    logic [IO_W-1:0]   io_wdata_d;

    logic [3:0]        we_mask_c;
    logic [31:0]       wdata_rep_c, rdata_ext_c;

`ifdef MEM_IO_TIMEOUT_EN
    localparam int unsigned TO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [TO_W-1:0] to_q, to_d;
`endif

    // Address decode of the incoming request.
    always_comb begin
        io_off   = req_addr - IO_BASE;
        io_idx   = io_off >> IO_STRIDE_LOG2;
        in_io    = (req_addr >= IO_BASE);
        io_bad   = (io_idx >= ADDR_W'(IO_CH)) || (io_off[IO_STRIDE_LOG2-1:0] != '0);
        misalign = (req_size == SZ_ILL) ||
                   ((req_size == SZ_H) && req_addr[0]) ||
                   ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
    end

    mem_lane_align u_align (
        .size        (req_d.size),
        .off         (addr_d[1:0]),
        .sgn         (req_d.sgn),
        .wdata       (req_d.wdata),
        .rdata       (mem_rdata),
        .we_mask_c   (we_mask_c),
        .wdata_rep_c (wdata_rep_c),
        .rdata_ext_c (rdata_ext_c)
    );

    // Next state, request latch and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        err_d       = err_q;
        ch_d        = ch_q;
        lat_d       = lat_q;
        rsp_rdata_d = rsp_rdata;
`ifdef MEM_IO_TIMEOUT_EN
        to_d        = to_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_d  = '{write: req_write, size: req_size, sgn: req_signed, wdata: req_wdata};
                    addr_d = req_addr;
                    ch_d   = CH_W'(io_idx);
                    err_d  = 1'b0;
                    lat_d  = '0;
`ifdef MEM_IO_TIMEOUT_EN
                    to_d   = '0;
`endif
                    if (misalign || (in_io && io_bad)) begin
                        err_d       = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = ST_RESP;
                    end else if (in_io) begin
                        state_d = ST_IO;
                    end else begin
                        state_d = ST_MEM;
                    end
                end
            end
            ST_MEM: begin
                if (req_q.write) begin
                    rsp_rdata_d = '0;
                    state_d     = ST_RESP;
                end else begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (lat_q == LAT_W'(MEM_LAT - 1)) begin
                    rsp_rdata_d = rdata_ext_c;
                    state_d     = ST_RESP;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_IO: begin
                if (io_ready[ch_q]) begin
                    rsp_rdata_d = req_q.write ? 32'd0 : 32'(io_rdata[ch_q*IO_W +: IO_W]);
                    state_d     = ST_RESP;
                end
`ifdef MEM_IO_TIMEOUT_EN
                else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    err_d       = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = ST_RESP;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
`endif
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        rsp_err_d   = (state_d == ST_RESP) && err_d;
        mem_en_d    = (state_d == ST_MEM);
        mem_we_d    = (mem_en_d && req_d.write) ? we_mask_c : 4'b0000;
        mem_addr_d  = mem_en_d ? {addr_d[ADDR_W-1:2], 2'b00} : '0;
        mem_wdata_d = (mem_en_d && req_d.write) ? wdata_rep_c : 32'd0;
        io_cs_d     = (state_d == ST_IO) ? (IO_CH'(1) << ch_d) : '0;
        io_we_d     = (state_d == ST_IO) && req_d.write;
        io_wdata_d  = (state_d == ST_IO) ? req_d.wdata[IO_W-1:0] : '0;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            ch_q      <= '0;
            lat_q     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            io_cs     <= '0;
            io_we     <= 1'b0;
            io_wdata  <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            ch_q      <= ch_d;
            lat_q     <= lat_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            io_cs     <= io_cs_d;
            io_we     <= io_we_d;
            io_wdata  <= io_wdata_d;
        end
    end

`ifdef MEM_IO_TIMEOUT_EN
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) to_q <= '0;
        else        to_q <= to_d;
    end
`endif

endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge: byte-level memory reference model, RAM/IO responders.
module tb_mem_io_bridge;

    localparam int unsigned    MEM_LAT     = 1;
    localparam int unsigned    TIMEOUT_CYC = 255;
    localparam int unsigned    IO_CH       = 4;
    localparam logic [31:0]    IO_BASE     = 32'hFFFF_FC00;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        rsp_valid, rsp_err, mem_en, io_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [3:0]  mem_we, io_cs;
    logic [15:0] io_wdata;
    logic [63:0] io_rdata = '0;
    logic [3:0]  io_ready = '0;

    mem_io_bridge #(.MEM_LAT(MEM_LAT), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clock(clock), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .io_cs(io_cs), .io_we(io_we), .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ready(io_ready)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] data; logic err; int unsigned cyc; } rsp_exp_t;
    typedef struct { logic [31:0] addr; logic [3:0] we; logic [31:0] wdata; bit store; } mem_exp_t;
    typedef struct { logic [3:0] cs; logic we; logic [15:0] wdata; } io_exp_t;

    rsp_exp_t rsp_q[$];
    mem_exp_t mem_q[$];
    io_exp_t  io_q[$];

    int          n_checks = 0, n_err = 0;
    int unsigned cyc = 0;
    bit          busy = 0;
    int          io_delay = 0, io_cnt = 0;
    logic [3:0]  io_prev = '0;
    bit [7:0]    ref_mem [int unsigned];
    bit [31:0]   ram [int unsigned];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit [7:0] ref_byte(input int unsigned a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Word RAM with one-cycle read latency; garbage on the read bus otherwise.
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we != 4'b0000) begin
                bit [31:0] w;
                w = ram.exists(mem_addr >> 2) ? ram[mem_addr >> 2] : 32'd0;
                for (int l = 0; l < 4; l++) if (mem_we[l]) w[8*l +: 8] = mem_wdata[8*l +: 8];
                ram[mem_addr >> 2] = w;
                mem_rdata <= $urandom;
            end else begin
                mem_rdata <= ram.exists(mem_addr >> 2) ? ram[mem_addr >> 2] : 32'd0;
            end
        end else begin
            mem_rdata <= $urandom;
        end
    end

    // IO peripheral: raises ready io_delay cycles after chip-select appears.
    always @(negedge clock) begin
        if (io_cs != 4'b0000) begin
            io_ready = (io_cnt >= io_delay) ? io_cs : 4'b0000;
            io_cnt++;
        end else begin
            io_ready = 4'b0000;
            io_cnt   = 0;
        end
    end

    // Monitor: strobes and responses against the scoreboard queues.
    always @(negedge clock) begin
        if (rst_n) begin
            check("req_ready", 32'(req_ready), 32'(!busy));
            if (mem_en) begin
                if (mem_q.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL mem_strobe: unexpected mem_en addr 0x%08h at cycle %0d", mem_addr, cyc);
                end else begin
                    mem_exp_t m;
                    m = mem_q.pop_front();
                    check("mem_addr", mem_addr, m.addr);
                    check("mem_we", 32'(mem_we), 32'(m.we));
                    if (m.store) check("mem_wdata", mem_wdata, m.wdata);
                end
            end
            if (io_cs != 4'b0000 && io_prev == 4'b0000) begin
                if (io_q.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL io_strobe: unexpected io_cs 0x%0h at cycle %0d", io_cs, cyc);
                end else begin
                    io_exp_t e;
                    e = io_q.pop_front();
                    check("io_cs", 32'(io_cs), 32'(e.cs));
                    check("io_we", 32'(io_we), 32'(e.we));
                    check("io_wdata", 32'(io_wdata), 32'(e.wdata));
                end
            end
            io_prev = io_cs;
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL rsp: unexpected rsp_valid data 0x%08h at cycle %0d", rsp_rdata, cyc);
                end else begin
                    rsp_exp_t r;
                    r = rsp_q.pop_front();
                    check("rsp_cycle", cyc, r.cyc);
                    check("rsp_rdata", rsp_rdata, r.data);
                    check("rsp_err", 32'(rsp_err), 32'(r.err));
                end
                busy = 0;
            end
        end
    end

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while (busy || !req_ready) begin
            n++;
            if (n > 400) begin
                n_checks++; n_err++;
                $display("FAIL idle_wait: bridge did not return to idle at cycle %0d", cyc);
                $display("Result: errors=%0d of %0d checks", n_err, n_checks);
                $fatal(1, "hung");
            end
            @(negedge clock);
        end
    endtask

    // Computes the expected outcome from the address map and byte memory, then drives the request.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, input int io_d, input logic [63:0] iord,
                         input bit expect_rsp);
        rsp_exp_t    r;
        int unsigned nb, off, lat, ch, ioff;
        bit          is_io, err;
        logic [31:0] v;
        logic [3:0]  we;
        wait_idle();
        nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off   = a % 4;
        is_io = (a >= IO_BASE);
        ioff  = a - IO_BASE;
        ch    = ioff / 16;
        err   = (sz == 2'd3) || (off % nb != 0) || (is_io && (ch >= IO_CH || ioff % 16 != 0));
        r.err = err;
        r.data = 32'd0;
        if (err) begin
            lat = 1;
        end else if (is_io) begin
            io_delay = io_d;
            io_rdata = iord;
            io_q.push_back('{cs: 4'(1 << ch), we: wr, wdata: wd[15:0]});
            if (!wr) r.data = 32'((iord >> (ch * 16)) & 64'hFFFF);
            lat = 2 + io_d;
`ifdef MEM_IO_TIMEOUT_EN
            if (io_d >= int'(TIMEOUT_CYC)) begin
                r.err = 1; r.data = 32'd0; lat = TIMEOUT_CYC + 1;
            end
`endif
        end else if (wr) begin
            we = 4'b0000;
            for (int i = 0; i < int'(nb); i++) begin
                ref_mem[a + i] = wd[8*i +: 8];
                we[off + i]    = 1'b1;
            end
            for (int l = 0; l < 4; l++) v[8*l +: 8] = wd[8*(l % nb) +: 8];
            mem_q.push_back('{addr: a & ~32'd3, we: we, wdata: v, store: 1});
            lat = 2;
        end else begin
            v = 32'd0;
            for (int i = 0; i < int'(nb); i++) v = v | (32'(ref_byte(a + i)) << (8 * i));
            if (sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            r.data = v;
            mem_q.push_back('{addr: a & ~32'd3, we: 4'b0000, wdata: 32'd0, store: 0});
            lat = 2 + MEM_LAT;
        end
        r.cyc = cyc + lat;
        if (expect_rsp) rsp_q.push_back(r);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clock);
        busy = 1;
        @(negedge clock);
        req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_io_cs", 32'(io_cs), 32'd0);
        check("rst_io_we", 32'(io_we), 32'd0);
        check("rst_io_wdata", 32'(io_wdata), 32'd0);
        @(negedge clock);
        rst_n = 1'b1;

        issue(1, 2'd2, 0, 32'h10, 32'h1234_5678, 0, 64'd0, 1);
        issue(0, 2'd0, 1, 32'h13, 32'd0, 0, 64'd0, 1);
        issue(1, 2'd1, 0, 32'h22, 32'h0000_BEEF, 0, 64'd0, 1);
        issue(0, 2'd1, 1, 32'h22, 32'd0, 0, 64'd0, 1);
        issue(0, 2'd1, 0, 32'h22, 32'd0, 0, 64'd0, 1);
        issue(0, 2'd2, 0, 32'hFFFF_FC10, 32'd0, 3, 64'h0000_0000_A5A5_0000, 1);
        issue(0, 2'd2, 0, 32'h6, 32'd0, 0, 64'd0, 1);
        issue(0, 2'd2, 0, 32'hFFFF_FC40, 32'd0, 0, 64'd0, 1);
        issue(1, 2'd3, 0, 32'h8, 32'hDEAD_BEEF, 0, 64'd0, 1);
        issue(1, 2'd1, 0, 32'h0, 32'hCAFE_F00D, 0, 64'd0, 1);
        issue(1, 2'd2, 0, 32'hFFFF_FC30, 32'h0000_5A3C, 1, 64'd0, 1);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) < 2) begin
                a = IO_BASE + 32'($urandom_range(0, 5) * 16);
                if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 15));
            end else begin
                a = 32'($urandom_range(0, 63));
                if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            end
            issue(1'($urandom), sz, 1'($urandom), a, $urandom, int'($urandom_range(0, 3)),
                  {$urandom, $urandom}, 1);
        end

`ifdef MEM_IO_TIMEOUT_EN
        issue(0, 2'd2, 0, IO_BASE, 32'd0, 100000, 64'h1234, 1);
`endif

        // Reset during MEM_WAIT: transaction is dropped without a response.
        issue(0, 2'd2, 0, 32'h10, 32'd0, 0, 64'd0, 0);
        @(posedge clock);
        #2;
        rst_n = 1'b0;
        busy  = 0;
        #1;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_mem_en", 32'(mem_en), 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        issue(0, 2'd0, 0, 32'h11, 32'd0, 0, 64'd0, 1);

        repeat (10) @(negedge clock);
        check("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
        check("mem_queue_empty", 32'(mem_q.size()), 32'd0);
        check("io_queue_empty", 32'(io_q.size()), 32'd0);
        finish_run();
    end

endmodule
